// File: rtl/sm3_pkg.sv
// +--------------------------------------------------------------------------+
// | sm3_pkg: SM3 constants, round helpers and shared types for sm3_cf_core.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package sm3_pkg;

  // Word 7 is A (bits [255:224]), word 0 is H.
  typedef logic [7:0][31:0] sm3_state_t;

  localparam sm3_state_t IV = {32'h7380166f, 32'h4914b2b9, 32'h172442d7, 32'hda8a0600,
                               32'ha96f30bc, 32'h163138aa, 32'he38dee4d, 32'hb0fb0e4e};

  localparam logic [31:0] TJ0 = 32'h79cc4519;
  localparam logic [31:0] TJ1 = 32'h7a879d8a;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] t;
    t = {x, x} << n;
    return t[63:32];
  endfunction

  function automatic logic [31:0] p0(input logic [31:0] x);
    return x ^ rotl32(x, 5'd9) ^ rotl32(x, 5'd17);
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rotl32(x, 5'd15) ^ rotl32(x, 5'd23);
  endfunction

  function automatic bit r_is_legal(input int r);
    return (r == 1) || (r == 2) || (r == 4) || (r == 8) || (r == 16);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sm3_round.sv
// +--------------------------------------------------------------------------+
// | sm3_round: one combinational SM3 compression round (state j -> j+1).     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module sm3_round
  import sm3_pkg::*;
(
  input  sm3_state_t  state_in,
  input  logic [5:0]  j,
  input  logic [31:0] wj,
  input  logic [31:0] wpj,
  output sm3_state_t  state_out
);

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] a12, tj_rot, ss1, ss2, ff, gg, tt1, tt2;
  logic        early;

  assign {a, b, c, d, e, f, g, h} = state_in;
  assign early = (j < 6'd16);

  assign a12    = rotl32(a, 5'd12);
  assign tj_rot = rotl32(early ? TJ0 : TJ1, j[4:0]);
  assign ss1    = rotl32(a12 + e + tj_rot, 5'd7);
  assign ss2    = ss1 ^ a12;

  assign ff = early ? (a ^ b ^ c) : ((a & b) | (a & c) | (b & c));
  assign gg = early ? (e ^ f ^ g) : ((e & f) | (~e & g));

  assign tt1 = ff + d + ss2 + wpj;
  assign tt2 = gg + h + ss1 + wj;

  assign state_out = {tt1, a, rotl32(b, 5'd9), c, p0(tt2), e, rotl32(f, 5'd19), g};

endmodule

`default_nettype wire

// File: rtl/sm3_cf_core.sv
// +--------------------------------------------------------------------------+
// | sm3_cf_core: SM3 compression engine, ROUNDS_PER_CYCLE rounds per clock.  |
// | Optional abort input enabled by defining SM3_CF_ABORT_EN.   Rev 1.0      |
// +--------------------------------------------------------------------------+
`default_nettype none

module sm3_cf_core
  import sm3_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_first,
  input  logic [511:0] in_block,
  output logic         out_valid,
  input  logic         out_ready,
`ifdef SM3_CF_ABORT_EN
  input  logic         abort,
`endif
  output logic [255:0] v_out,
  output logic         busy
);

  localparam int R  = ROUNDS_PER_CYCLE;
  localparam int NX = R + 16;

  if (!r_is_legal(R)) begin : g_bad_r
    $error("sm3_cf_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  logic [1:0]            state_q, state_d;
  logic [6:0]            j_q, j_d, j_nxt;
  logic [15:0][31:0]     w_q, w_d;
  logic [NX-1:0][31:0]   ext;
  sm3_state_t            st_q, st_d, vs_q, vs_d, chain_q, chain_d, v_out_q, v_out_d;
  logic                  out_valid_q, out_valid_d;
  logic                  accept, last_run, do_abort;
  sm3_state_t            rnd [R+1];

`ifdef SM3_CF_ABORT_EN
  assign do_abort = abort && (state_q != ST_IDLE);
`else
  assign do_abort = 1'b0;
`endif

  assign accept   = in_valid && (state_q == ST_IDLE);
  assign j_nxt    = j_q + 7'(R);
  assign last_run = (state_q == ST_RUN) && (j_nxt == 7'd64);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort overrides completion and handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)  state_d = ST_RUN;
      ST_RUN:  if (last_run)  state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
    if (do_abort) state_d = ST_IDLE;
  end

  // Output logic
  always_comb begin
    in_ready = (state_q == ST_IDLE);
    busy     = (state_q != ST_IDLE);
  end

  // Message expansion: window words plus the R new words needed this cycle
  always_comb begin
    ext = '0;
    for (int i = 0; i < 16; i++) ext[i] = w_q[i];
    for (int i = 16; i < NX; i++)
      ext[i] = p1(ext[i-16] ^ ext[i-9] ^ rotl32(ext[i-3], 5'd15))
             ^ rotl32(ext[i-13], 5'd7) ^ ext[i-6];
  end

  assign rnd[0] = st_q;
  for (genvar k = 0; k < R; k++) begin : g_round
    sm3_round u_round (
      .state_in  (rnd[k]),
      .j         (j_q[5:0] + 6'(k)),
      .wj        (ext[k]),
      .wpj       (ext[k] ^ ext[k+4]),
      .state_out (rnd[k+1])
    );
  end

  always_comb begin
    w_d         = w_q;
    j_d         = j_q;
    st_d        = st_q;
    vs_d        = vs_q;
    chain_d     = chain_q;
    v_out_d     = v_out_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      for (int i = 0; i < 16; i++) w_d[i] = in_block[511-32*i -: 32];
      vs_d = in_first ? IV : chain_q;
      st_d = vs_d;
      j_d  = 7'd0;
    end else if (state_q == ST_RUN && !do_abort) begin
      for (int i = 0; i < 16; i++) w_d[i] = ext[R+i];
      st_d = rnd[R];
      j_d  = j_nxt;
      if (last_run) begin
        v_out_d     = rnd[R] ^ vs_q;
        chain_d     = rnd[R] ^ vs_q;
        out_valid_d = 1'b1;
      end
    end
    if ((state_q == ST_DONE && out_ready) || do_abort) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q         <= '0;
      j_q         <= 7'd0;
      st_q        <= '0;
      vs_q        <= '0;
      chain_q     <= IV;
      v_out_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      w_q         <= w_d;
      j_q         <= j_d;
      st_q        <= st_d;
      vs_q        <= vs_d;
      chain_q     <= chain_d;
      v_out_q     <= v_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign v_out     = v_out_q;
  assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_sm3_cf_core.sv
// +--------------------------------------------------------------------------+
// | tb_sm3_cf_core: directed-vector bench for sm3_cf_core (R=1 plus R sweep).|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_sm3_cf_core;

  localparam logic [255:0] ABC_DIGEST  = 256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
  localparam logic [255:0] ABCD_DIGEST = 256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732;
  localparam logic [511:0] ABC_BLK  = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] ABCD_BLK = {16{32'h61626364}};
  localparam logic [511:0] PAD_BLK  = {32'h80000000, {14{32'h0}}, 32'h00000200};
  localparam int RS [4] = '{2, 4, 8, 16};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_first = 1'b0;
  logic [511:0] in_block = '0;
  logic         out_ready = 1'b1;
  logic         in_ready, out_valid, busy;
  logic [255:0] v_out;
`ifdef SM3_CF_ABORT_EN
  logic         abort = 1'b0;
`endif

  logic         sw_valid = 1'b0;
  logic         sw_ir [4];
  logic         sw_ov [4];
  logic         sw_busy [4];
  logic [255:0] sw_v [4];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sm3_cf_core #(.ROUNDS_PER_CYCLE(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_first  (in_first),
    .in_block  (in_block),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef SM3_CF_ABORT_EN
    .abort     (abort),
`endif
    .v_out     (v_out),
    .busy      (busy)
  );

  for (genvar g = 0; g < 4; g++) begin : g_sweep
    sm3_cf_core #(.ROUNDS_PER_CYCLE(RS[g])) u_sw (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (sw_valid),
      .in_ready  (sw_ir[g]),
      .in_first  (1'b1),
      .in_block  (ABC_BLK),
      .out_valid (sw_ov[g]),
      .out_ready (1'b1),
`ifdef SM3_CF_ABORT_EN
      .abort     (1'b0),
`endif
      .v_out     (sw_v[g]),
      .busy      (sw_busy[g])
    );
  end

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one block, then count edges from accept until out_valid rises.
  task automatic run_block(input logic [511:0] blk, input logic first,
                           output int lat, output logic [255:0] res);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin step(); n++; end
    in_block = blk;
    in_first = first;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_block = '0;
    in_first = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin step(); lat++; end
    res = v_out;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int bad;
    int seen;
    int sw_lat [4];
    logic [255:0] sw_res [4];
    logic [255:0] res;

    // Reset state
    repeat (2) step();
    rst_n = 1'b1;
    step();
    check("rst_in_ready", 256'(in_ready), 256'(1));
    check("rst_out_valid", 256'(out_valid), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_v_out", v_out, 256'h0);

    // Single block "abc"
    run_block(ABC_BLK, 1'b1, lat, res);
    check("abc_latency", 256'(lat), 256'(64));
    check("abc_digest", res, ABC_DIGEST);
    step();
    check("abc_hs_out_valid", 256'(out_valid), 256'(0));
    check("abc_hs_in_ready", 256'(in_ready), 256'(1));

    // Two-block "abcd" x16 via internal chaining
    run_block(ABCD_BLK, 1'b1, lat, res);
    check("abcd_blk1_latency", 256'(lat), 256'(64));
    run_block(PAD_BLK, 1'b0, lat, res);
    check("abcd_digest", res, ABCD_DIGEST);
    step();

    // Backpressure: DONE held for 20 cycles, stray in_valid ignored
    out_ready = 1'b0;
    run_block(ABC_BLK, 1'b1, lat, res);
    check("bp_digest", res, ABC_DIGEST);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin in_block = PAD_BLK; in_first = 1'b1; in_valid = 1'b1; end
      step();
      in_valid = 1'b0;
      if (v_out !== ABC_DIGEST || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    check("bp_hold_errors", 256'(bad), 256'(0));
    check("bp_busy", 256'(busy), 256'(1));
    in_block  = ABC_BLK;
    in_first  = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    check("bp_release_out_valid", 256'(out_valid), 256'(0));
    check("bp_release_in_ready", 256'(in_ready), 256'(1));
    step();
    in_valid = 1'b0;
    check("bp_next_accepted", 256'(in_ready), 256'(0));
    lat = 0;
    while (!out_valid && lat < 200) begin step(); lat++; end
    check("bp_next_latency", 256'(lat), 256'(64));
    check("bp_next_digest", v_out, ABC_DIGEST);
    step();

    // Reset in the middle of RUN (chain currently holds the "abc" digest)
    in_block = ABCD_BLK;
    in_first = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (30) step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 256'(out_valid), 256'(0));
    check("mid_rst_in_ready", 256'(in_ready), 256'(1));
    check("mid_rst_busy", 256'(busy), 256'(0));
    check("mid_rst_v_out", v_out, 256'h0);
    step();
    rst_n = 1'b1;
    step();
    run_block(ABC_BLK, 1'b0, lat, res);
    check("post_rst_chain_iv", res, ABC_DIGEST);
    step();

    // Latency sweep over ROUNDS_PER_CYCLE = 2, 4, 8, 16
    for (int g = 0; g < 4; g++) begin sw_lat[g] = 0; sw_res[g] = '0; end
    sw_valid = 1'b1;
    step();
    sw_valid = 1'b0;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      step();
      for (int g = 0; g < 4; g++)
        if (sw_ov[g] && sw_lat[g] == 0) begin sw_lat[g] = cyc; sw_res[g] = sw_v[g]; end
    end
    for (int g = 0; g < 4; g++) begin
      check($sformatf("sweep_r%0d_latency", RS[g]), 256'(sw_lat[g]), 256'(64 / RS[g]));
      check($sformatf("sweep_r%0d_digest", RS[g]), sw_res[g], ABC_DIGEST);
    end

`ifdef SM3_CF_ABORT_EN
    // Abort at round 10 of block 2; chain must still hold block-1 result
    run_block(ABCD_BLK, 1'b1, lat, res);
    step();
    in_block = PAD_BLK;
    in_first = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (10) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_out_valid", 256'(out_valid), 256'(0));
    check("abort_in_ready", 256'(in_ready), 256'(1));
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      step();
      if (out_valid) seen++;
    end
    check("abort_no_output", 256'(seen), 256'(0));
    run_block(PAD_BLK, 1'b0, lat, res);
    check("abort_resubmit_digest", res, ABCD_DIGEST);
    step();
`else
    seen = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sm3_cf_core.md
# sm3_cf_core

Parametrised SM3 compression-function engine: accepts one 512-bit padded message block per transaction, runs the 64 SM3 rounds at `ROUNDS_PER_CYCLE` rounds per clock, and returns the feed-forward chaining value V(i+1) = CF(V(i), B(i)). It keeps an internal chaining register, so multi-block messages need no external feedback. It uses valid/ready handshakes on input and output, and sits between the SM3 padding/block-feeder and the digest consumer in the hash datapath.

## Interface
- `ROUNDS_PER_CYCLE`, default 1: number of SM3 rounds unrolled per clock. Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  block offered.
- `in_ready`  out  1  block can be accepted.
- `in_first`  in  1  1: start from the standard IV; 0: start from the internal chaining register.
- `in_block`  in  512  message block, W0 in bits [511:480].
- `out_valid`  out  1  `v_out` holds a result.
- `out_ready`  in  1  consumer takes the result.
- `v_out`  out  256  V(i+1), A in bits [255:224].
- `busy`  out  1  state is not IDLE.

## Operation
- States are IDLE, RUN and DONE.
- `in_ready` = (state == IDLE).
- Accept is `in_valid && in_ready` at a clock edge. On accept:
  - load W[0..15] from `in_block`;
  - load V_start from IV (`in_first`=1) or from `chain` (`in_first`=0);
  - load the working register ABCDEFGH with V_start;
  - set round counter `j` to 0 and go to RUN.
- RUN, each edge:
  - apply `ROUNDS_PER_CYCLE` rounds j, j+1, …;
  - advance the W window by `ROUNDS_PER_CYCLE` words, generating W16 on the fly;
  - add `ROUNDS_PER_CYCLE` to `j` (7-bit counter).
- Round rules:
  - FF/GG boolean form and T are selected per round: rounds 0–15 use XOR and T=79cc4519; rounds 16–63 use majority/choose and T=7a879d8a.
  - T is rotated by (j mod 32).
  - W'j = Wj ^ Wj+4.
  - All additions are mod 2^32.
- On the edge where `j` reaches 64, in the same edge:
  - `v_out` ← ABCDEFGH ^ V_start;
  - `chain` ← ABCDEFGH ^ V_start;
  - `out_valid` ← 1;
  - go to DONE.
- DONE: `v_out` is held stable. At `out_valid && out_ready`, go to IDLE and `out_valid` ← 0.
- `in_valid` is ignored outside IDLE. `in_block` and `in_first` are sampled only at the accept edge.

## Timing
- Reset values: `in_ready`=1 (IDLE), `out_valid`=0, `busy`=0, `v_out`=0, `chain`=IV, W=0, `j`=0.
- Latency: `out_valid` rises exactly 64/`ROUNDS_PER_CYCLE` edges after the accept edge. That is 64 for R=1 and 4 for R=16.
- Throughput: one block per 64/R + 2 cycles when `out_ready` is tied to 1 (accept, RUN edges, DONE handshake edge). The next accept happens the edge after the handshake.
- `out_ready` may be held high early; the handshake then completes on the first DONE cycle.
- Backpressure: DONE lasts until `out_ready` is sampled high. `chain` is already updated, so a following `in_first`=0 block chains correctly regardless of handshake delay.
- `in_first`=0 immediately after reset uses IV, because `chain` resets to IV.
- Reset mid-operation (`rst_n` low in RUN or DONE): return immediately to reset values, with no output pulse. The partial result is lost.

## Configuration
- `SM3_CF_ABORT_EN`, when defined:
  - adds input `abort` (1 bit);
  - `abort`=1 sampled in RUN or DONE forces IDLE on that edge with `out_valid` ← 0;
  - `chain` is left unchanged if the abort arrives in RUN; a result already in DONE has updated `chain` and is kept;
  - `abort` in IDLE has no effect;
  - `abort` takes priority over completion on the same edge.
- When undefined: no `abort` port and no abort logic.

## Structure
- Package `sm3_pkg` holds:
  - IV localparam (7380166f 4914b2b9 172442d7 da8a0600 a96f30bc 163138aa e38dee4d b0fb0e4e);
  - TJ0 and TJ1;
  - functions `p0` and `p1` and rotate-left `rotl32`;
  - typedef `sm3_state_t` (8×32);
  - the legal-R check.
- Sub-module `sm3_round`: one purely combinational round. Inputs are the state, `j`, Wj and W'j; output is the next state. It is instantiated `ROUNDS_PER_CYCLE` times in a generate chain, each instance with `j`+k.
- The message-expansion window stays in `sm3_cf_core`.

## Test plan
- Single block "abc": `in_block` = 61626380 followed by zero words and final word 00000018, with `in_first`=1. Required `v_out` = 66c7f0f4 62eeedd9 d1f2d46b dc10e4e2 4167c487 5cf2f7a2 297da02b 8f4ba8e0.
- Two-block "abcd"×16: block 1 with `in_first`=1, then the padding block (80000000, zero words, final word 00000200) with `in_first`=0. Required final `v_out` = debe9ff9 2275b8a1 38604889 c18e5a4d 6fdb70e5 387e5765 293dcba3 9c0c5732.
- Latency sweep: run the "abc" case for R = 1, 2, 4, 8, 16. `out_valid` must rise exactly 64, 32, 16, 8 and 4 edges after accept, with identical digests.
- Backpressure: hold `out_ready`=0 for 20 cycles after `out_valid`. `v_out` stays stable, `in_ready`=0, and an `in_valid` pulse during this window is not accepted. After release, the next block accepts one edge after the handshake.
- Reset mid-RUN: assert `rst_n` low at round 30. `out_valid`=0, `in_ready`=1. A following `in_first`=0 "abc" block must give the `in_first`=1 "abc" digest.
- With `SM3_CF_ABORT_EN`: abort at round 10 of block 2 of the two-block test. No `out_valid`. Resubmitting block 2 with `in_first`=0 gives debe9ff9… (chain preserved).
